// File: rtl/pll_cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_seq_pkg
// Brief    : Shared channel state encoding and default parameter values for
//            the PLL configuration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pll_cfg_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_APPLY     = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_RUN       = 3'd5,
        ST_ERR       = 3'd6
    } chan_state_e;

    localparam int c_DEF_NUM_PLL       = 3;
    localparam int c_DEF_REF_DIV_WIDTH = 4;
    localparam int c_DEF_FB_DIV_WIDTH  = 12;
    localparam int c_DEF_DRAIN_CYCLES  = 4;
    localparam int c_DEF_LOCK_BLANK    = 2;
    localparam int c_DEF_LOCK_STABLE   = 8;
    localparam int c_DEF_LOCK_TIMEOUT  = 64;
    localparam int c_DEF_CL_SRC_MASK   = 3;

endpackage
`default_nettype wire

// File: rtl/pll_cfg_seq_chan.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_chan
// Brief    : One PLL channel: lock synchroniser, gate/reset/apply/lock
//            sequencing FSM and applied divider registers.
// Revision : 1.0 - initial release
// ============================================================================
module pll_cfg_chan
    import pll_cfg_seq_pkg::*;
#(
    parameter int REF_DIV_WIDTH = c_DEF_REF_DIV_WIDTH,
    parameter int FB_DIV_WIDTH  = c_DEF_FB_DIV_WIDTH,
    parameter int DRAIN_CYCLES  = c_DEF_DRAIN_CYCLES,
    parameter int LOCK_BLANK    = c_DEF_LOCK_BLANK,
    parameter int LOCK_STABLE   = c_DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT  = c_DEF_LOCK_TIMEOUT
) (
    input  logic                     slow_clk,
    input  logic                     glob_arst_ni,
    input  logic [REF_DIV_WIDTH-1:0] i_ref_div,
    input  logic [FB_DIV_WIDTH-1:0]  i_fb_div,
    input  logic                     i_valid,
    input  logic                     i_locked,
    output logic                     o_ready,
    output logic [REF_DIV_WIDTH-1:0] o_ref_div,
    output logic [FB_DIV_WIDTH-1:0]  o_fb_div,
    output logic                     o_dom_en,
    output logic                     o_dom_arst_n,
    output logic                     o_lock_err
);

    localparam int c_CNT_W  = $clog2(LOCK_TIMEOUT + DRAIN_CYCLES + 1);
    localparam int c_STAB_W = $clog2(LOCK_STABLE + 1);

    chan_state_e               r_state;
    logic [1:0]                r_sync;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_STAB_W-1:0]       r_stab;
    logic [REF_DIV_WIDTH-1:0]  r_cap_ref;
    logic [FB_DIV_WIDTH-1:0]   r_cap_fb;
    logic [REF_DIV_WIDTH-1:0]  r_ref;
    logic [FB_DIV_WIDTH-1:0]   r_fb;
    logic                      r_ready;
    logic                      r_en;
    logic                      r_arst_n;
    logic                      r_err;

    logic w_sync;
    logic w_xfer;
    logic w_cap_zero;
    logic w_past_blank;

    assign w_sync       = r_sync[1];
    assign w_xfer       = i_valid & r_ready;
    assign w_cap_zero   = (r_cap_ref == '0) || (r_cap_fb == '0);
    assign w_past_blank = (r_cnt >= c_CNT_W'(LOCK_BLANK));

    // r_cnt counts drain cycles in DRAIN and total cycles in WAIT_LOCK.
    always_ff @(posedge slow_clk or negedge glob_arst_ni) begin
        if (!glob_arst_ni) begin
            r_state   <= ST_OFF;
            r_sync    <= '0;
            r_cnt     <= '0;
            r_stab    <= '0;
            r_cap_ref <= '0;
            r_cap_fb  <= '0;
            r_ref     <= '0;
            r_fb      <= '0;
            r_ready   <= 1'b0;
            r_en      <= 1'b0;
            r_arst_n  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_locked};
            if (w_xfer) begin
                // Ready is only high in OFF/RUN/ERR; a transfer wins over lock loss.
                r_cap_ref <= i_ref_div;
                r_cap_fb  <= i_fb_div;
                r_state   <= ST_DRAIN;
                r_cnt     <= '0;
                r_ready   <= 1'b0;
                r_en      <= 1'b0;
                r_arst_n  <= 1'b0;
                r_err     <= 1'b0;
            end else begin
                case (r_state)
                    ST_OFF: r_ready <= 1'b1;
                    ST_DRAIN: begin
                        if (r_cnt == c_CNT_W'(DRAIN_CYCLES - 1)) begin
                            r_state <= ST_APPLY;
                            r_ref   <= w_cap_zero ? '0 : r_cap_ref;
                            r_fb    <= w_cap_zero ? '0 : r_cap_fb;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_APPLY: begin
                        r_cnt  <= '0;
                        r_stab <= '0;
                        if (w_cap_zero) begin
                            r_state <= ST_OFF;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_LOCK;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (w_past_blank && w_sync && (r_stab == c_STAB_W'(LOCK_STABLE - 1))) begin
                            r_state  <= ST_RELEASE;
                            r_arst_n <= 1'b1;
                        end else if (r_cnt == c_CNT_W'(LOCK_TIMEOUT - 1)) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                            r_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (w_past_blank) begin
                                r_stab <= w_sync ? r_stab + 1'b1 : '0;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        r_state <= ST_RUN;
                        r_en    <= 1'b1;
                        r_ready <= 1'b1;
                    end
                    ST_RUN: begin
                        if (!w_sync) begin
                            r_state  <= ST_WAIT_LOCK;
                            r_cnt    <= '0;
                            r_stab   <= '0;
                            r_en     <= 1'b0;
                            r_arst_n <= 1'b0;
                            r_ready  <= 1'b0;
                        end
                    end
                    ST_ERR: begin
                    end
                    default: begin
                        r_state <= ST_OFF;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_ready      = r_ready;
    assign o_ref_div    = r_ref;
    assign o_fb_div     = r_fb;
    assign o_dom_en     = r_en;
    assign o_dom_arst_n = r_arst_n;
    assign o_lock_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/pll_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_seq
// Brief    : Multi-channel PLL configuration sequencer with ratio-based
//            core-link clock source selection.
// Revision : 1.0 - initial release
// ============================================================================
module pll_cfg_seq
    import pll_cfg_seq_pkg::*;
#(
    parameter int                 NUM_PLL       = c_DEF_NUM_PLL,
    parameter int                 REF_DIV_WIDTH = c_DEF_REF_DIV_WIDTH,
    parameter int                 FB_DIV_WIDTH  = c_DEF_FB_DIV_WIDTH,
    parameter int                 DRAIN_CYCLES  = c_DEF_DRAIN_CYCLES,
    parameter int                 LOCK_BLANK    = c_DEF_LOCK_BLANK,
    parameter int                 LOCK_STABLE   = c_DEF_LOCK_STABLE,
    parameter int                 LOCK_TIMEOUT  = c_DEF_LOCK_TIMEOUT,
    parameter logic [NUM_PLL-1:0] CL_SRC_MASK   = NUM_PLL'(c_DEF_CL_SRC_MASK),
    localparam int                c_SEL_W       = (NUM_PLL > 1) ? $clog2(NUM_PLL) : 1
) (
    input  logic                                    slow_clk,
    input  logic                                    glob_arst_ni,
    input  logic [NUM_PLL-1:0][REF_DIV_WIDTH-1:0]   cfg_ref_div_i,
    input  logic [NUM_PLL-1:0][FB_DIV_WIDTH-1:0]    cfg_fb_div_i,
    input  logic [NUM_PLL-1:0]                      cfg_valid_i,
    output logic [NUM_PLL-1:0]                      cfg_ready_o,
    input  logic [NUM_PLL-1:0]                      pll_locked_i,
    output logic [NUM_PLL-1:0][REF_DIV_WIDTH-1:0]   pll_ref_div_o,
    output logic [NUM_PLL-1:0][FB_DIV_WIDTH-1:0]    pll_fb_div_o,
    output logic [NUM_PLL-1:0]                      dom_en_o,
    output logic [NUM_PLL-1:0]                      dom_arst_no,
    output logic [NUM_PLL-1:0]                      lock_err_o,
    output logic [c_SEL_W-1:0]                      clk_src_sel_o,
    output logic                                    clk_src_vld_o
);

    localparam int c_PROD_W = FB_DIV_WIDTH + REF_DIV_WIDTH;

    for (genvar g = 0; g < NUM_PLL; g++) begin : g_chan
        pll_cfg_chan #(
            .REF_DIV_WIDTH (REF_DIV_WIDTH),
            .FB_DIV_WIDTH  (FB_DIV_WIDTH),
            .DRAIN_CYCLES  (DRAIN_CYCLES),
            .LOCK_BLANK    (LOCK_BLANK),
            .LOCK_STABLE   (LOCK_STABLE),
            .LOCK_TIMEOUT  (LOCK_TIMEOUT)
        ) u_chan (
            .slow_clk     (slow_clk),
            .glob_arst_ni (glob_arst_ni),
            .i_ref_div    (cfg_ref_div_i[g]),
            .i_fb_div     (cfg_fb_div_i[g]),
            .i_valid      (cfg_valid_i[g]),
            .i_locked     (pll_locked_i[g]),
            .o_ready      (cfg_ready_o[g]),
            .o_ref_div    (pll_ref_div_o[g]),
            .o_fb_div     (pll_fb_div_o[g]),
            .o_dom_en     (dom_en_o[g]),
            .o_dom_arst_n (dom_arst_no[g]),
            .o_lock_err   (lock_err_o[g])
        );
    end

    logic [c_SEL_W-1:0]       r_idx;
    logic [c_SEL_W-1:0]       r_best;
    logic [REF_DIV_WIDTH-1:0] r_best_ref;
    logic [FB_DIV_WIDTH-1:0]  r_best_fb;
    logic                     r_any;
    logic [c_SEL_W-1:0]       r_sel;
    logic                     r_vld;

    logic [REF_DIV_WIDTH-1:0] w_cand_ref;
    logic [FB_DIV_WIDTH-1:0]  w_cand_fb;
    logic [c_PROD_W-1:0]      w_lhs;
    logic [c_PROD_W-1:0]      w_rhs;
    logic                     w_elig;
    logic                     w_take;
    logic                     w_last;

    // Frequency ratio fb/ref compared by cross-multiplication; strict > keeps the lower index on ties.
    assign w_cand_ref = pll_ref_div_o[r_idx];
    assign w_cand_fb  = pll_fb_div_o[r_idx];
    assign w_lhs      = c_PROD_W'(w_cand_fb) * c_PROD_W'(r_best_ref);
    assign w_rhs      = c_PROD_W'(r_best_fb) * c_PROD_W'(w_cand_ref);
    assign w_elig     = CL_SRC_MASK[r_idx] & dom_en_o[r_idx];
    assign w_take     = w_elig & (~r_any | (w_lhs > w_rhs));
    assign w_last     = (r_idx == c_SEL_W'(NUM_PLL - 1));

    always_ff @(posedge slow_clk or negedge glob_arst_ni) begin
        if (!glob_arst_ni) begin
            r_idx      <= '0;
            r_best     <= '0;
            r_best_ref <= '0;
            r_best_fb  <= '0;
            r_any      <= 1'b0;
            r_sel      <= '0;
            r_vld      <= 1'b0;
        end else if (w_last) begin
            r_idx <= '0;
            r_any <= 1'b0;
            if (r_any | w_elig) begin
                r_sel <= w_take ? r_idx : r_best;
                r_vld <= 1'b1;
            end else begin
                r_vld <= 1'b0;
            end
        end else begin
            r_idx <= r_idx + 1'b1;
            if (w_take) begin
                r_any      <= 1'b1;
                r_best     <= r_idx;
                r_best_ref <= w_cand_ref;
                r_best_fb  <= w_cand_fb;
            end
        end
    end

    assign clk_src_sel_o = r_sel;
    assign clk_src_vld_o = r_vld;

endmodule
`default_nettype wire

// File: doc/pll_cfg_seq.md
# pll_cfg_seq

Multi-channel PLL configuration sequencer for the clock/reset subsystem, clocked by the divided `slow_clk`. It replaces per-PLL fixed divider sampling with one parametrised block of `NUM_PLL` channels. Each channel accepts divider updates through a valid/ready handshake and sequences its domain through gate-off, reset, divider apply, qualified lock, reset release and enable. It also selects the fastest running eligible PLL as the core-link clock source by exact ratio comparison, with no division.

## Interface
- `NUM_PLL`, default 3: number of PLL channels (≥1).
- `REF_DIV_WIDTH`, default 4: reference divider width.
- `FB_DIV_WIDTH`, default 12: feedback divider width.
- `DRAIN_CYCLES`, default 4: cycles the domain is held gated and in reset before new dividers are applied (≥1).
- `LOCK_BLANK`, default 2: cycles after apply during which lock is ignored (≥2, covers synchroniser).
- `LOCK_STABLE`, default 8: consecutive synced-lock cycles required (≥1).
- `LOCK_TIMEOUT`, default 64: maximum cycles in WAIT_LOCK, blank included (> `LOCK_BLANK` + `LOCK_STABLE`).
- `CL_SRC_MASK`, default `NUM_PLL'b011`: channels eligible as core-link source.
- `slow_clk`  in  1  sequencer clock.
- `glob_arst_ni`  in  1  reset, asynchronous, active-low.
- `cfg_ref_div_i`  in  `[NUM_PLL][REF_DIV_WIDTH]`  requested reference divider.
- `cfg_fb_div_i`  in  `[NUM_PLL][FB_DIV_WIDTH]`  requested feedback divider.
- `cfg_valid_i`  in  `[NUM_PLL]`  configuration request.
- `cfg_ready_o`  out  `[NUM_PLL]`  channel accepts a request.
- `pll_locked_i`  in  `[NUM_PLL]`  raw PLL lock, asynchronous to `slow_clk`.
- `pll_ref_div_o`  out  `[NUM_PLL][REF_DIV_WIDTH]`  applied reference divider.
- `pll_fb_div_o`  out  `[NUM_PLL][FB_DIV_WIDTH]`  applied feedback divider.
- `dom_en_o`  out  `[NUM_PLL]`  domain clock-gate enable.
- `dom_arst_no`  out  `[NUM_PLL]`  domain reset, active-low.
- `lock_err_o`  out  `[NUM_PLL]`  lock timeout flag, sticky.
- `clk_src_sel_o`  out  `$clog2(NUM_PLL)` (min 1)  selected core-link source index.
- `clk_src_vld_o`  out  1  at least one eligible channel is running.

## Operation
- **Reset values.** All outputs are 0. Channel state is OFF. Scan index is 0.
- **Lock synchroniser.** `pll_locked_i` passes through a 2-flop synchroniser per channel. All lock decisions use the synced value.
- **Handshake.** A transfer occurs on the edge where `cfg_valid_i[c] & cfg_ready_o[c]`; the dividers are captured on that edge.
  - `cfg_ready_o[c]`=1 only in OFF, RUN and ERR.
  - Valid asserted while ready=0 is held off; no capture occurs.
- **Channel states:** OFF, DRAIN, APPLY, WAIT_LOCK, RELEASE, RUN, ERR.
- **OFF:** en=0, rst=0. Transfer → DRAIN.
- **DRAIN:** en=0, rst=0 for `DRAIN_CYCLES` cycles → APPLY.
- **APPLY:** divider outputs load the captured values on entry; lasts 1 cycle.
  - If either captured divider is 0 → OFF, with 0 driven on both divider outputs (power-down request).
  - Otherwise → WAIT_LOCK.
- **WAIT_LOCK:** en=0, rst=0.
  - The first `LOCK_BLANK` cycles are ignored.
  - After that, a stability counter counts consecutive synced-lock=1 cycles and clears on any 0.
  - Counter reaching `LOCK_STABLE` → RELEASE.
  - `LOCK_TIMEOUT` total cycles in this state → ERR. Stable-reach wins if both occur in the same cycle.
- **RELEASE:** rst=1, en=0 for 1 cycle → RUN.
- **RUN:** rst=1, en=1.
  - Synced lock=0 → WAIT_LOCK with the counters cleared. en and rst go to 0 on that same edge.
  - A transfer in the same cycle as lock loss takes priority → DRAIN.
- **ERR:** en=0, rst=0, `lock_err_o`=1. Transfer → DRAIN and clears `lock_err_o`.
- **Source selection.**
  - The scan index steps 0…`NUM_PLL`-1 one channel per cycle, then wraps to 0.
  - Candidate c is eligible if `CL_SRC_MASK[c]` is set and c is in RUN.
  - Best-so-far is replaced when `fb_c·ref_best > fb_best·ref_c`. Products are `FB_DIV_WIDTH+REF_DIV_WIDTH` bits unsigned, computed from the applied dividers. Ties keep the lower index.
  - At the wrap cycle, if any channel was eligible: commit best to `clk_src_sel_o` and set valid=1.
  - If none was eligible: valid=0 and `clk_src_sel_o` holds its last value.

## Timing
- Lock synchroniser latency: 2 cycles.
- With a transfer at edge 0 and lock already stable high:
  - DRAIN covers cycles 1..`DRAIN_CYCLES`.
  - APPLY at `DRAIN_CYCLES`+1.
  - RELEASE at `DRAIN_CYCLES`+2+`LOCK_BLANK`+`LOCK_STABLE`; RUN one cycle later.
  - With defaults: divider outputs change at cycle 5, `dom_arst_no` rises at 16, `dom_en_o` rises at 17.
- `dom_arst_no` always rises exactly 1 cycle before `dom_en_o`. `dom_en_o` always falls no later than `dom_arst_no`.
- Source selection settles within 2·`NUM_PLL` cycles of any RUN entry or exit.
- Asynchronous reset mid-sequence forces all outputs to their reset values immediately and discards any captured configuration.

## Structure
- **Package `pll_cfg_seq_pkg`:** the `chan_state_e` enum and default parameter constants.
- **Sub-module `pll_cfg_chan`:** lock synchroniser, per-channel FSM, counters and divider registers. Instantiated `NUM_PLL` times through a generate loop.
- **Top level:** the scan comparator and selection registers.

## Test plan
Settings: defaults, `NUM_PLL`=3, `CL_SRC_MASK`=3'b011.

- **Ch0 nominal:** cfg 4/100 at edge 0, lock tied high → dividers 4/100 at cycle 5, rst high at 16, en high at 17, ready=1 from 17.
- **Ch1 timeout:** cfg 2/50, lock held 0 → ERR at the 64th WAIT_LOCK cycle with `lock_err_o`=1. A new cfg then clears the error and restarts DRAIN.
- **Ch0 lock loss in RUN:** lock dropped for 1 cycle → en=0 and rst=0 two edges later, then re-qualification via blank and stable to RUN.
- **Zero divider:** cfg ref=0 on ch2 → OFF after APPLY, dividers 0, en=0, rst=0.
- **Selection:** ch0 4/100, ch1 2/100, ch2 1/200 (masked) all in RUN → sel=1, vld=1. Change ch1 to 2/50 (tie) → sel=0. All channels OFF → vld=0 and sel holds.
- **Reset:** async reset asserted mid-DRAIN → all outputs 0 at once; ready=1 after release.
